// File: rtl/uart_pkg.sv
// uart_pkg
// Definitions shared by the UART command receiver and the planned transmitter:
//   - uart_state_e : receiver FSM state encoding
//   - CMD_*        : command codes carried on the PC command line
//   - ERR_BIT      : index of the error flag in the 9-bit received word
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic [7:0] CMD_DLY_INC = 8'h11;
    localparam logic [7:0] CMD_DLY_DEC = 8'h12;
    localparam logic [7:0] CMD_ATT_INC = 8'h19;
    localparam logic [7:0] CMD_ATT_DEC = 8'h1A;
    localparam logic [7:0] CMD_RESTORE = 8'h1F;

    localparam int ERR_BIT = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick
// Free-running bit-period counter with a synchronous restart.
//   clk       : system clock
//   rst       : asynchronous active-high reset (counter to 0)
//   restart   : hold the counter at 0 (it counts again from the following cycle)
//   half_tick : counter has reached HALF_CYC-1 (half a bit since restart)
//   bit_tick  : counter has reached BIT_CYC-1; the counter wraps to 0 next cycle
module uart_baud_tick #(
    parameter int BIT_CYC = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic half_tick,
    output logic bit_tick
);

    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CNT_W    = $clog2(BIT_CYC);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (restart || bit_tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign half_tick = (cnt_reg == CNT_W'(HALF_CYC - 1));
    assign bit_tick  = (cnt_reg == CNT_W'(BIT_CYC - 1));

endmodule

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx
// UART receiver for the PC command line feeding the echo canceller.
//   clk        : system clock, the only clock
//   rst        : asynchronous active-high reset
//   uart_rx    : serial line, idle high, asynchronous to clk
//   rs232_data : [7:0] received byte (LSB first on the wire),
//                [8] error flag (stop bit low or parity mismatch)
//   rs232_flag : one-cycle strobe, rs232_data valid in the same cycle
//   rx_busy    : a frame is in progress (FSM not idle)
module uart_cmd_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             uart_rx,
    output logic [ERR_BIT:0] rs232_data,
    output logic             rs232_flag,
    output logic             rx_busy
);

    localparam int   BIT_CYC     = CLK_FREQ / BAUD_RATE;
    localparam logic PAR_ODD_BIT = (PARITY_ODD != 0);

    generate
        if (BIT_CYC < 8) begin : g_bit_cyc_check
            $error("uart_cmd_rx: CLK_FREQ/BAUD_RATE must be at least 8");
        end
    endgenerate

    // Two synchroniser flops plus a history flop for falling-edge detection.
    // All preset to 1 so that leaving reset never looks like a start bit.
    logic sync1_reg, sync2_reg, hist_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            hist_reg  <= 1'b1;
        end else begin
            sync1_reg <= uart_rx;
            sync2_reg <= sync1_reg;
            hist_reg  <= sync2_reg;
        end
    end

    logic line_fall;
    assign line_fall = hist_reg & ~sync2_reg;

    uart_state_e state_reg, state_next;
    logic [2:0]  bit_cnt_reg, bit_cnt_next;
    logic [7:0]  shift_reg, shift_next;
    logic        par_err_reg, par_err_next;
    logic        stop_bad_reg, stop_bad_next;
    logic        done_reg, done_next;
    logic        restart, half_tick, bit_tick;

    uart_baud_tick #(
        .BIT_CYC (BIT_CYC)
    ) u_baud (
        .clk       (clk),
        .rst       (rst),
        .restart   (restart),
        .half_tick (half_tick),
        .bit_tick  (bit_tick)
    );

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        par_err_next  = par_err_reg;
        stop_bad_next = stop_bad_reg;
        done_next     = 1'b0;
        restart       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // Counter parked at 0 so START measures from the edge.
                restart = 1'b1;
                if (line_fall) begin
                    par_err_next = 1'b0;
                    state_next   = ST_START;
                end
            end
            ST_START: begin
                if (half_tick) begin
                    if (!sync2_reg) begin
                        // Mid start bit: from here every full period is mid-bit.
                        restart      = 1'b1;
                        bit_cnt_next = 3'd0;
                        state_next   = ST_DATA;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shift_next   = {sync2_reg, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    par_err_next = (^shift_reg) ^ sync2_reg ^ PAR_ODD_BIT;
                    state_next   = ST_STOP;
                end
            end
            ST_STOP: begin
                // Leave half a bit early so a back-to-back start edge is caught.
                if (bit_tick) begin
                    stop_bad_next = ~sync2_reg;
                    done_next     = 1'b1;
                    state_next    = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            bit_cnt_reg  <= 3'd0;
            shift_reg    <= 8'd0;
            par_err_reg  <= 1'b0;
            stop_bad_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            par_err_reg  <= par_err_next;
            stop_bad_reg <= stop_bad_next;
            done_reg     <= done_next;
        end
    end

    // Output word is held until the next completed frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs232_data <= '0;
            rs232_flag <= 1'b0;
        end else begin
            rs232_flag <= done_reg;
            if (done_reg) begin
                rs232_data <= {stop_bad_reg | par_err_reg, shift_reg};
            end
        end
    end

    assign rx_busy = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_rx.sv
`timescale 1ns/1ps
module tb_uart_cmd_rx;
    import uart_pkg::*;

    // 1 MHz clock, 100 kbaud: 10 clk per bit. Unit 0 is 8N1, unit 1 is 8E1.
    localparam int BIT  = 10;
    localparam int HALF = BIT / 2;
    // Edge seen 3 clk after the fall, half a bit in START, 8 data bits and
    // the stop sample one full bit apart each, output one clk later.
    localparam int FLAG_LAT = 3 + HALF + 9 * BIT + 1;
    localparam int BUSY_END = 3 + HALF + 9 * BIT - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] rx_w = 2'b11;
    logic [8:0] data_w [2];
    logic [1:0] flag_w;
    logic [1:0] busy_w;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_cmd_rx #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_EN(0), .PARITY_ODD(0)
    ) dut (
        .clk(clk), .rst(rst), .uart_rx(rx_w[0]),
        .rs232_data(data_w[0]), .rs232_flag(flag_w[0]), .rx_busy(busy_w[0])
    );

    uart_cmd_rx #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_EN(1), .PARITY_ODD(0)
    ) dut_p (
        .clk(clk), .rst(rst), .uart_rx(rx_w[1]),
        .rs232_data(data_w[1]), .rs232_flag(flag_w[1]), .rx_busy(busy_w[1])
    );

    // Model: per unit, a list of expected (cycle, word) strobes and one busy window.
    int         e_cyc [2][512];
    logic [8:0] e_dat [2][512];
    int         e_wr [2] = '{0, 0};
    int         e_rd [2] = '{0, 0};
    int         busy_lo [2] = '{1, 1};
    int         busy_hi [2] = '{0, 0};
    logic [8:0] m_data [2] = '{9'h0, 9'h0};
    int         flag_cnt [2] = '{0, 0};
    int         last_cyc [2] = '{0, 0};
    int         prev_cyc [2] = '{0, 0};
    logic [8:0] last_dat [2] = '{9'h0, 9'h0};
    logic [8:0] prev_dat [2] = '{9'h0, 9'h0};
    int         last_rst_cyc = 0;
    int         checks = 0;
    int         errors = 0;

    always @(negedge clk) begin
        int   slot;
        logic exp_b;
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                checks++;
                if (flag_w[u] !== 1'b0 || busy_w[u] !== 1'b0 || data_w[u] !== 9'h0) begin
                    errors++;
                    $display("FAIL reset_outputs unit %0d cyc %0d: data %03h flag %b busy %b, required 000 0 0",
                             u, cyc, data_w[u], flag_w[u], busy_w[u]);
                end
                m_data[u]    = 9'h0;
                e_rd[u]      = e_wr[u];
                last_rst_cyc = cyc;
            end else begin
                if (flag_w[u] === 1'b1) begin
                    $display("RX unit %0d cyc %0d data %03h", u, cyc, data_w[u]);
                    flag_cnt[u]++;
                    prev_cyc[u] = last_cyc[u];
                    prev_dat[u] = last_dat[u];
                    last_cyc[u] = cyc;
                    last_dat[u] = data_w[u];
                    checks++;
                    if (e_rd[u] == e_wr[u]) begin
                        errors++;
                        $display("FAIL unexpected_flag unit %0d cyc %0d: data %03h, required no strobe",
                                 u, cyc, data_w[u]);
                    end else begin
                        slot = e_rd[u] % 512;
                        if (cyc != e_cyc[u][slot] || data_w[u] !== e_dat[u][slot]) begin
                            errors++;
                            $display("FAIL flag_word unit %0d: cyc %0d data %03h, required cyc %0d data %03h",
                                     u, cyc, data_w[u], e_cyc[u][slot], e_dat[u][slot]);
                        end
                        m_data[u] = e_dat[u][slot];
                        e_rd[u]++;
                    end
                end else if (e_rd[u] != e_wr[u] && cyc >= e_cyc[u][e_rd[u] % 512]) begin
                    slot = e_rd[u] % 512;
                    checks++;
                    errors++;
                    $display("FAIL missed_flag unit %0d cyc %0d: no strobe, required data %03h at cyc %0d",
                             u, cyc, e_dat[u][slot], e_cyc[u][slot]);
                    e_rd[u]++;
                end
                checks++;
                if (data_w[u] !== m_data[u]) begin
                    errors++;
                    $display("FAIL data_hold unit %0d cyc %0d: data %03h, required %03h",
                             u, cyc, data_w[u], m_data[u]);
                end
                exp_b = (cyc >= busy_lo[u]) && (cyc <= busy_hi[u]) && (busy_lo[u] > last_rst_cyc);
                checks++;
                if (busy_w[u] !== exp_b) begin
                    errors++;
                    $display("FAIL rx_busy unit %0d cyc %0d: busy %b, required %b",
                             u, cyc, busy_w[u], exp_b);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Drives one complete frame and records what the receiver must report.
    // Unit 1 carries a parity bit; even parity, so an odd total count is an error.
    task automatic send_frame(input int u, input logic [7:0] b, input logic stop_bit,
                              input logic par_bit);
        int   n;
        int   extra;
        logic err;
        n     = cyc;
        extra = (u == 1) ? BIT : 0;
        err   = !stop_bit;
        if (u == 1 && (((^b) ^ par_bit) != 1'b0)) err = 1'b1;
        e_cyc[u][e_wr[u] % 512] = n + FLAG_LAT + extra;
        e_dat[u][e_wr[u] % 512] = {err, b};
        e_wr[u]    = e_wr[u] + 1;
        busy_lo[u] = n + 3;
        busy_hi[u] = n + BUSY_END + extra;
        rx_w[u] = 1'b0;
        step(BIT);
        for (int i = 0; i < 8; i++) begin
            rx_w[u] = b[i];
            step(BIT);
        end
        if (u == 1) begin
            rx_w[u] = par_bit;
            step(BIT);
        end
        rx_w[u] = stop_bit;
        step(BIT);
    endtask

    logic [7:0] cmds [5] = '{CMD_DLY_INC, CMD_DLY_DEC, CMD_ATT_INC, CMD_ATT_DEC, CMD_RESTORE};

    initial begin
        int         f0;
        int         n;
        logic [7:0] b;
        logic       sb;
        logic       pb;
        int         gap;

        #1 rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(5);
        check("reset_data", int'(data_w[0]), 0);
        check("reset_busy", int'(busy_w[0]), 0);

        // Single clean command byte.
        f0 = flag_cnt[0];
        send_frame(0, CMD_DLY_INC, 1'b1, 1'b0);
        step(2);
        check("dly_inc_count", flag_cnt[0] - f0, 1);
        check("dly_inc_data", int'(last_dat[0]), 'h011);

        // Three-clock start glitch: busy for half a bit, no strobe.
        n = cyc;
        busy_lo[0] = n + 3;
        busy_hi[0] = n + 3 + HALF - 1;
        rx_w[0] = 1'b0;
        step(3);
        rx_w[0] = 1'b1;
        step(20);
        check("glitch_count", flag_cnt[0] - f0, 1);
        check("glitch_data_held", int'(data_w[0]), 'h011);
        check("glitch_busy", int'(busy_w[0]), 0);

        // Stop bit low, then the line stays low (break) before release.
        send_frame(0, CMD_RESTORE, 1'b0, 1'b0);
        step(50);
        rx_w[0] = 1'b1;
        step(30);
        check("break_count", flag_cnt[0] - f0, 2);
        check("break_data", int'(last_dat[0]), 'h11F);

        // Back-to-back frames with no idle gap.
        send_frame(0, CMD_ATT_INC, 1'b1, 1'b0);
        send_frame(0, CMD_ATT_DEC, 1'b1, 1'b0);
        step(2);
        check("b2b_first", int'(prev_dat[0]), 'h019);
        check("b2b_second", int'(last_dat[0]), 'h01A);
        check("b2b_spacing", last_cyc[0] - prev_cyc[0], 100);

        // Even parity on unit 1.
        send_frame(1, CMD_DLY_DEC, 1'b1, 1'b0);
        step(2);
        check("parity_ok", int'(last_dat[1]), 'h012);
        send_frame(1, CMD_DLY_DEC, 1'b1, 1'b1);
        step(2);
        check("parity_bad", int'(last_dat[1]), 'h112);

        // Reset during data bit 4 of 0x11; the sender abandons the frame too.
        n = cyc;
        busy_lo[0] = n + 3;
        busy_hi[0] = n + BUSY_END;
        b = CMD_DLY_INC;
        rx_w[0] = 1'b0;
        step(BIT);
        for (int i = 0; i < 4; i++) begin
            rx_w[0] = b[i];
            step(BIT);
        end
        rx_w[0] = b[4];
        step(3);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        rx_w[0] = 1'b1;
        check("rst_mid_data", int'(data_w[0]), 0);
        check("rst_mid_flag", int'(flag_w[0]), 0);
        check("rst_mid_busy", int'(busy_w[0]), 0);
        step(30);
        f0 = flag_cnt[0];
        send_frame(0, CMD_DLY_DEC, 1'b1, 1'b0);
        step(2);
        check("after_rst_count", flag_cnt[0] - f0, 1);
        check("after_rst_data", int'(last_dat[0]), 'h012);

        // Randomised traffic, 8N1. A framing error needs idle high before the next start.
        for (int k = 0; k < 30; k++) begin
            b   = (k % 4 == 0) ? cmds[$urandom_range(0, 4)] : 8'($urandom);
            sb  = ($urandom_range(0, 7) != 0);
            gap = sb ? $urandom_range(0, 12) : $urandom_range(2, 12);
            send_frame(0, b, sb, 1'b0);
            rx_w[0] = 1'b1;
            step(gap);
        end

        // Randomised traffic with parity.
        for (int k = 0; k < 20; k++) begin
            b   = 8'($urandom);
            pb  = 1'($urandom);
            sb  = ($urandom_range(0, 7) != 0);
            gap = sb ? $urandom_range(0, 12) : $urandom_range(2, 12);
            send_frame(1, b, sb, pb);
            rx_w[1] = 1'b1;
            step(gap);
        end

        step(20);
        check("pending_unit0", e_wr[0] - e_rd[0], 0);
        check("pending_unit1", e_wr[1] - e_rd[1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
